// File: rtl/sfr_uart.sv
// sfr_uart: 8051 serial port (SCON/SBUF) as an SFR-bus responder.
// Mode-1 UART only: 8N1, LSB first, CLKS_PER_BIT clocks per bit.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ram_rd_en_sfr/rd_addr    SFR read strobe and address from the core
//   ram_wr_en_sfr/wr_addr/   SFR write strobe, address and data
//   ram_wr_byte
//   sfr_rd_byte/sfr_rd_hit   registered read data and "this block answered"
//   rxd / txd                serial input (asynchronous) / output (idle high)
//   irq                      registered TI | RI
module sfr_uart #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SCON_ADDR    = 8'h98,
    parameter logic [7:0]  SBUF_ADDR    = 8'h99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ram_rd_en_sfr,
    input  logic [7:0] ram_rd_addr,
    input  logic       ram_wr_en_sfr,
    input  logic [7:0] ram_wr_addr,
    input  logic [7:0] ram_wr_byte,
    output logic [7:0] sfr_rd_byte,
    output logic       sfr_rd_hit,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

    // SCON bit positions
    localparam int unsigned B_REN = 4;
    localparam int unsigned B_RB8 = 2;
    localparam int unsigned B_TI  = 1;
    localparam int unsigned B_RI  = 0;

    logic [7:0]       scon_q, scon_d;
    logic [7:0]       rx_buf_q;
    logic [7:0]       rd_byte_q;
    logic             rd_hit_q;
    logic             irq_q;

    uart_st_e         tx_st_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             txd_q;

    uart_st_e         rx_st_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;

    logic             scon_wr, sbuf_wr, tx_done, rx_load, ren;

    assign scon_wr = ram_wr_en_sfr && (ram_wr_addr == SCON_ADDR);
    assign sbuf_wr = ram_wr_en_sfr && (ram_wr_addr == SBUF_ADDR);
    assign ren     = scon_q[B_REN];
    assign tx_done = (tx_st_q == ST_STOP) && (tx_cnt_q == CNT_LAST);
    // Frame is accepted only with a good stop bit and RI already consumed.
    assign rx_load = ren && (rx_st_q == ST_STOP) && (rx_cnt_q == CNT_LAST)
                     && rx_s2_q && !scon_q[B_RI];

    // SCON update: software write first, hardware flag sets override it.
    always_comb begin
        scon_d = scon_q;
        if (scon_wr) begin
            scon_d        = ram_wr_byte;
            scon_d[B_RB8] = scon_q[B_RB8];
        end
        if (tx_done) scon_d[B_TI] = 1'b1;
        if (rx_load) begin
            scon_d[B_RB8] = 1'b1;
            scon_d[B_RI]  = 1'b1;
        end
    end

    // SCON, interrupt and read-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scon_q    <= 8'h00;
            irq_q     <= 1'b0;
            rd_byte_q <= 8'h00;
            rd_hit_q  <= 1'b0;
        end else begin
            scon_q <= scon_d;
            irq_q  <= scon_q[B_TI] | scon_q[B_RI];
            if (ram_rd_en_sfr && (ram_rd_addr == SCON_ADDR)) begin
                rd_byte_q <= scon_q;
                rd_hit_q  <= 1'b1;
            end else if (ram_rd_en_sfr && (ram_rd_addr == SBUF_ADDR)) begin
                rd_byte_q <= rx_buf_q;
                rd_hit_q  <= 1'b1;
            end else begin
                rd_byte_q <= 8'h00;
                rd_hit_q  <= 1'b0;
            end
        end
    end

    // Transmitter; SBUF writes are only accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q    <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            case (tx_st_q)
                ST_IDLE: begin
                    if (sbuf_wr) begin
                        tx_shift_q <= ram_wr_byte;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_st_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= 3'd0;
                        tx_st_q    <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            tx_st_q <= ST_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_st_q  <= ST_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_st_q <= ST_IDLE;
            endcase
        end
    end

    // rxd synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Receiver; START realigns sampling to mid-bit, REN low aborts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st_q    <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
        end else if (!ren) begin
            rx_st_q  <= ST_IDLE;
            rx_cnt_q <= '0;
        end else begin
            case (rx_st_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= 3'd0;
                        rx_st_q  <= rx_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_st_q <= ST_STOP;
                        else                  rx_bit_q <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= ST_IDLE;
                        if (rx_load) rx_buf_q <= rx_shift_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_st_q <= ST_IDLE;
            endcase
        end
    end

    assign sfr_rd_byte = rd_byte_q;
    assign sfr_rd_hit  = rd_hit_q;
    assign txd         = txd_q;
    assign irq         = irq_q;

endmodule
